// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/decode/execute control sequencer.
//
// Fetches a 16-bit instruction as two bytes (low, then high), with PC
// incrementing on each fetch edge. It then decodes the opcode and holds in
// EXEC until the execute stage reports completion.
//
// Ports
//   Clock        system clock, rising-edge
//   Reset        synchronous, active-low
//   Start        begin fetching (sampled in IDLE only)
//   ExecDone     execute stage finished (sampled in EXEC only)
//   IROut[15:0]  instruction register contents from the datapath
//   ARF_OutDSel  address-bus source select (2'b00 = PC)
//   ARF_FunSel   ARF function (2'b11 = increment)
//   ARF_RegSel   active-low per-register enable, bit0 = PC
//   Mem_CS       memory chip select, active-low
//   Mem_WR       memory write (0 = read)
//   IR_Enable    IR load enable
//   IR_LH        IR half select (0 = low byte, 1 = high byte)
//   IR_Funsel    IR function (2'b01 = load)
//   T[7:0]       one-hot timing signal, 8'h00 when not sequencing
//   Opcode[3:0]  registered opcode of the current instruction
//   Busy         high while sequencing an instruction
//   InsCount     completed-instruction counter (wraps)
module fetch_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        ExecDone,
  input  logic [15:0] IROut,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        IR_Enable,
  output logic        IR_LH,
  output logic [1:0]  IR_Funsel,
  output logic [7:0]  T,
  output logic [3:0]  Opcode,
  output logic        Busy,
  output logic [7:0]  InsCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_LO,
    S_FETCH_HI,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] t_nxt;
  logic       fetch_nxt;

  // Only the opcode field is decoded here; the operand bits belong to the
  // execute stage.
  logic unused_ir;
  assign unused_ir = ^IROut[11:0];

  always_comb begin
    state_nxt = state;
    t_nxt     = T;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt = S_FETCH_LO;
          t_nxt     = 8'h01;
        end
      end
      S_FETCH_LO: begin
        state_nxt = S_FETCH_HI;
        t_nxt     = 8'h02;
      end
      S_FETCH_HI: begin
        state_nxt = S_DECODE;
        t_nxt     = 8'h04;
      end
      S_DECODE: begin
        if (IROut[15:12] == 4'hF) begin
          state_nxt = S_HALT;
          t_nxt     = 8'h00;
        end else begin
          state_nxt = S_EXEC;
          t_nxt     = 8'h08;
        end
      end
      S_EXEC: begin
        if (ExecDone) begin
          state_nxt = S_FETCH_LO;
          t_nxt     = 8'h01;
        end else if (T != 8'h80) begin
          // Long instructions park on the last timing slot.
          t_nxt = T << 1;
        end
      end
      S_HALT: begin
        t_nxt = 8'h00;
      end
      default: begin
        state_nxt = S_IDLE;
        t_nxt     = 8'h00;
      end
    endcase
  end

  assign fetch_nxt = (state_nxt == S_FETCH_LO) || (state_nxt == S_FETCH_HI);

  // Outputs are registered from the next state, so they are a pure function
  // of the current state register (Moore) while remaining glitch-free.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= S_IDLE;
      T           <= 8'h00;
      Opcode      <= 4'h0;
      InsCount    <= 8'h00;
      Busy        <= 1'b0;
      Mem_CS      <= 1'b1;
      Mem_WR      <= 1'b0;
      IR_Enable   <= 1'b0;
      IR_LH       <= 1'b0;
      IR_Funsel   <= 2'b00;
      ARF_RegSel  <= 4'b1111;
      ARF_FunSel  <= 2'b00;
      ARF_OutDSel <= 2'b00;
    end else begin
      state       <= state_nxt;
      T           <= t_nxt;
      Busy        <= (state_nxt == S_FETCH_LO) || (state_nxt == S_FETCH_HI) ||
                     (state_nxt == S_DECODE)   || (state_nxt == S_EXEC);
      // Both fetch states read memory at PC while incrementing PC, so the
      // IR byte load and PC+1 land on the same edge.
      Mem_CS      <= ~fetch_nxt;
      Mem_WR      <= 1'b0;
      IR_Enable   <= fetch_nxt;
      IR_LH       <= (state_nxt == S_FETCH_HI);
      IR_Funsel   <= fetch_nxt ? 2'b01 : 2'b00;
      ARF_RegSel  <= fetch_nxt ? 4'b1110 : 4'b1111;
      ARF_FunSel  <= fetch_nxt ? 2'b11 : 2'b00;
      ARF_OutDSel <= 2'b00;
      if (state == S_DECODE) begin
        Opcode <= IROut[15:12];
      end
      if ((state == S_EXEC) && ExecDone) begin
        InsCount <= InsCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: behavioural reference model feeding a
// scoreboard queue, plus directed checks on timing sequences and counters.
module tb_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        ExecDone;
  logic [15:0] IROut;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        Mem_CS;
  logic        Mem_WR;
  logic        IR_Enable;
  logic        IR_LH;
  logic [1:0]  IR_Funsel;
  logic [7:0]  T;
  logic [3:0]  Opcode;
  logic        Busy;
  logic [7:0]  InsCount;

  fetch_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .ExecDone   (ExecDone),
    .IROut      (IROut),
    .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel (ARF_FunSel),
    .ARF_RegSel (ARF_RegSel),
    .Mem_CS     (Mem_CS),
    .Mem_WR     (Mem_WR),
    .IR_Enable  (IR_Enable),
    .IR_LH      (IR_LH),
    .IR_Funsel  (IR_Funsel),
    .T          (T),
    .Opcode     (Opcode),
    .Busy       (Busy),
    .InsCount   (InsCount)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  t;
    logic [3:0]  op;
    logic        busy;
    logic [7:0]  cnt;
    logic [15:0] ctl;
  } exp_t;

  exp_t sb[$];

  localparam int M_IDLE = 0;
  localparam int M_FLO  = 1;
  localparam int M_FHI  = 2;
  localparam int M_DEC  = 3;
  localparam int M_EXEC = 4;
  localparam int M_HALT = 5;

  int         m_st  = M_IDLE;
  int         m_k   = 0;
  logic [3:0] m_op  = 4'h0;
  logic [7:0] m_cnt = 8'h00;

  function automatic exp_t model_out();
    exp_t e;
    logic fetch;
    fetch = (m_st == M_FLO) || (m_st == M_FHI);
    case (m_st)
      M_FLO:   e.t = 8'h01;
      M_FHI:   e.t = 8'h02;
      M_DEC:   e.t = 8'h04;
      M_EXEC:  e.t = (m_k >= 4) ? 8'h80 : (8'h08 << m_k);
      default: e.t = 8'h00;
    endcase
    e.op   = m_op;
    e.cnt  = m_cnt;
    e.busy = (m_st >= M_FLO) && (m_st <= M_EXEC);
    if (fetch)
      e.ctl = {4'b1110, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, (m_st == M_FHI), 2'b01, 2'b00};
    else
      e.ctl = {4'b1111, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    return e;
  endfunction

  function automatic logic [15:0] dut_ctl();
    return {ARF_RegSel, ARF_FunSel, ARF_OutDSel, Mem_CS, Mem_WR, IR_Enable, IR_LH,
            IR_Funsel, 2'b00};
  endfunction

  // Drive one cycle of inputs, advance the model, push its expectation and
  // compare once the DUT has taken the edge.
  task automatic step(input logic rst, input logic st, input logic ed, input logic [15:0] ir);
    exp_t e;
    Reset = rst; Start = st; ExecDone = ed; IROut = ir;
    if (!rst) begin
      m_st = M_IDLE; m_op = 4'h0; m_cnt = 8'h00; m_k = 0;
    end else begin
      case (m_st)
        M_IDLE: if (st) m_st = M_FLO;
        M_FLO:  m_st = M_FHI;
        M_FHI:  m_st = M_DEC;
        M_DEC: begin
          m_op = ir[15:12];
          m_k  = 0;
          m_st = (ir[15:12] == 4'hF) ? M_HALT : M_EXEC;
        end
        M_EXEC: begin
          if (ed) begin m_cnt = m_cnt + 8'd1; m_st = M_FLO; end
          else m_k++;
        end
        default: ;
      endcase
    end
    sb.push_back(model_out());
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    check("T", 64'(T), 64'(e.t));
    check("Opcode", 64'(Opcode), 64'(e.op));
    check("Busy", 64'(Busy), 64'(e.busy));
    check("InsCount", 64'(InsCount), 64'(e.cnt));
    check("ctrl", 64'(dut_ctl()), 64'(e.ctl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] tv [0:6];
    logic [7:0] exp_t_seq [0:6];
    logic [7:0] prev;
    int rs;
    int n;
    exp_t_seq[0] = 8'h08; exp_t_seq[1] = 8'h10; exp_t_seq[2] = 8'h20;
    exp_t_seq[3] = 8'h40; exp_t_seq[4] = 8'h80; exp_t_seq[5] = 8'h80;
    exp_t_seq[6] = 8'h80;

    // Reset for two cycles, then fetch 16'h1234 with stray ExecDone pulses.
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'h1234);
    check("rst_T", 64'(T), 64'h00);
    check("rst_RegSel", 64'(ARF_RegSel), 64'hF);
    rs = 0;
    step(1'b1, 1'b1, 1'b0, 16'h1234); rs += int'(ARF_RegSel == 4'b1110);
    check("seq_T0", 64'(T), 64'h01);
    check("seq_Busy", 64'(Busy), 64'h1);
    step(1'b1, 1'b0, 1'b1, 16'h1234); rs += int'(ARF_RegSel == 4'b1110);
    check("seq_T1", 64'(T), 64'h02);
    step(1'b1, 1'b0, 1'b1, 16'h1234); rs += int'(ARF_RegSel == 4'b1110);
    check("seq_T2", 64'(T), 64'h04);
    step(1'b1, 1'b0, 1'b1, 16'h1234); rs += int'(ARF_RegSel == 4'b1110);
    check("seq_T3", 64'(T), 64'h08);
    check("seq_Opcode", 64'(Opcode), 64'h1);
    check("regsel_cycles", 64'(rs), 64'd2);
    check("stray_done_cnt", 64'(InsCount), 64'h00);

    // Long EXEC with Start pulses: T saturates at 8'h80.
    tv[0] = T;
    for (int i = 1; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h1234);
      tv[i] = T;
    end
    for (int i = 0; i < 7; i++) check($sformatf("exec_T%0d", i), 64'(tv[i]), 64'(exp_t_seq[i]));
    step(1'b1, 1'b0, 1'b1, 16'h1234);
    check("done_T", 64'(T), 64'h01);
    check("done_cnt", 64'(InsCount), 64'h01);

    // Halting instruction.
    step(1'b1, 1'b0, 1'b0, 16'hF000);
    step(1'b1, 1'b0, 1'b0, 16'hF000);
    step(1'b1, 1'b0, 1'b0, 16'hF000);
    check("halt_T", 64'(T), 64'h00);
    check("halt_Busy", 64'(Busy), 64'h0);
    check("halt_Opcode", 64'(Opcode), 64'hF);
    check("halt_cnt", 64'(InsCount), 64'h01);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'h1234);
    check("halt_hold_T", 64'(T), 64'h00);
    check("halt_hold_cnt", 64'(InsCount), 64'h01);

    // Reset during FETCH_HI, with Start also high (reset wins).
    step(1'b0, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b1, 1'b0, 1'b0, 16'h1234);
    check("pre_rst_LH", 64'(IR_LH), 64'h1);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    check("mid_rst_T", 64'(T), 64'h00);
    check("mid_rst_CS", 64'(Mem_CS), 64'h1);
    check("mid_rst_IE", 64'(IR_Enable), 64'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'h1234);
    check("post_rst_Busy", 64'(Busy), 64'h0);

    // 256 minimum-length instructions: counter wraps.
    step(1'b0, 1'b0, 1'b0, 16'h2000);
    step(1'b1, 1'b1, 1'b1, 16'h2000);
    for (int i = 0; i < 256; i++) begin
      prev = InsCount;
      n = 0;
      do begin
        step(1'b1, 1'b0, 1'b1, 16'h2000);
        n++;
      end while ((InsCount == prev) && (n < 8));
      check("instr_len", 64'(n), 64'd4);
    end
    check("wrap_cnt", 64'(InsCount), 64'h00);
    check("wrap_Opcode", 64'(Opcode), 64'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
